// File: rtl/mouse_pkg.sv
// Shared constants and FSM state type for the PS/2 mouse init path.
package mouse_pkg;

    localparam int BYTE_WIDTH = 8;

    localparam logic [BYTE_WIDTH-1:0] CMD_RESET  = 8'hFF;
    localparam logic [BYTE_WIDTH-1:0] CMD_ENABLE = 8'hF4;

    localparam logic [BYTE_WIDTH-1:0] RSP_ACK    = 8'hFA;
    localparam logic [BYTE_WIDTH-1:0] RSP_RESEND = 8'hFE;
    localparam logic [BYTE_WIDTH-1:0] RSP_ERROR  = 8'hFC;
    localparam logic [BYTE_WIDTH-1:0] RSP_BAT_OK = 8'hAA;

    localparam logic [BYTE_WIDTH-1:0] ID_STD   = 8'h00;
    localparam logic [BYTE_WIDTH-1:0] ID_WHEEL = 8'h03;

    typedef enum logic [3:0] {
        SEND_RST,
        TXW_RST,
        WAIT_ACK_RST,
        WAIT_BAT,
        WAIT_ID,
        SEND_EN,
        TXW_EN,
        WAIT_ACK_EN,
        STREAM,
        ERROR
    } state_t;

    // States in which the timeout counter runs.
    function automatic logic is_waiting(state_t s);
        return (s == TXW_RST) || (s == WAIT_ACK_RST) || (s == WAIT_BAT) ||
               (s == WAIT_ID) || (s == TXW_EN) || (s == WAIT_ACK_EN);
    endfunction

endpackage

// File: rtl/mouse_timeout_timer.sv
// Saturating down-counter; expired while the count sits at zero.
module mouse_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic tick,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (tick && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/mouse_init_ctrl.sv
// PS/2 mouse init sequencer: reset, BAT/ID check, enable reporting, then stream.
module mouse_init_ctrl
    import mouse_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int MAX_RETRIES    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_restart,
    input  logic [BYTE_WIDTH-1:0] i_rx_byte,
    input  logic                  i_rx_valid,
    output logic [BYTE_WIDTH-1:0] o_tx_byte,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    input  logic                  i_tx_done,
    input  logic                  i_tx_err,
    output logic                  o_stream_en,
    output logic                  o_init_done,
    output logic                  o_init_error,
    output logic [1:0]            o_retry_cnt
);

    state_t state, state_next;
    logic   retry_req, retry_ok;
    logic   timer_load, timer_expired;

    mouse_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (timer_load),
        .tick    (is_waiting(state)),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SEND_RST;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        retry_req  = 1'b0;
        case (state)
            SEND_RST:  if (o_tx_valid && i_tx_ready) state_next = TXW_RST;
            SEND_EN:   if (o_tx_valid && i_tx_ready) state_next = TXW_EN;
            TXW_RST, TXW_EN: begin
                if (i_tx_err)           retry_req  = 1'b1;
                else if (i_tx_done)     state_next = (state == TXW_RST) ? WAIT_ACK_RST : WAIT_ACK_EN;
                else if (timer_expired) retry_req  = 1'b1;
            end
            WAIT_ACK_RST, WAIT_ACK_EN: begin
                if (i_rx_valid) begin
                    case (i_rx_byte)
                        RSP_ACK:    state_next = (state == WAIT_ACK_RST) ? WAIT_BAT : STREAM;
                        RSP_RESEND: retry_req  = 1'b1;
                        RSP_ERROR:  state_next = ERROR;
                        default:    ;
                    endcase
                end else if (timer_expired) begin
                    retry_req = 1'b1;
                end
            end
            WAIT_BAT: begin
                if (i_rx_valid) begin
                    if (i_rx_byte == RSP_BAT_OK)     state_next = WAIT_ID;
                    else if (i_rx_byte == RSP_ERROR) state_next = ERROR;
                end else if (timer_expired) begin
                    retry_req = 1'b1;
                end
            end
            WAIT_ID: begin
                if (i_rx_valid) begin
                    if ((i_rx_byte == ID_STD) || (i_rx_byte == ID_WHEEL)) state_next = SEND_EN;
                    else                                                  state_next = ERROR;
                end else if (timer_expired) begin
                    retry_req = 1'b1;
                end
            end
            default: ;
        endcase

        // A retry re-issues the command of the current phase.
        retry_ok = retry_req && (int'(o_retry_cnt) < MAX_RETRIES);
        if (retry_req) begin
            if (!retry_ok)                                     state_next = ERROR;
            else if ((state == TXW_EN) || (state == WAIT_ACK_EN)) state_next = SEND_EN;
            else                                               state_next = SEND_RST;
        end

        if (i_restart) state_next = SEND_RST;

        timer_load = is_waiting(state_next) && (state_next != state);
    end

    // Outputs are registered from the next state so they move with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_tx_valid   <= 1'b0;
            o_tx_byte    <= '0;
            o_stream_en  <= 1'b0;
            o_init_done  <= 1'b0;
            o_init_error <= 1'b0;
            o_retry_cnt  <= '0;
        end else begin
            o_tx_valid   <= (state_next == SEND_RST) || (state_next == SEND_EN);
            if (state_next == SEND_RST)     o_tx_byte <= CMD_RESET;
            else if (state_next == SEND_EN) o_tx_byte <= CMD_ENABLE;
            o_stream_en  <= (state_next == STREAM);
            o_init_done  <= (state_next == STREAM);
            o_init_error <= (state_next == ERROR);
            if (i_restart || (state_next == STREAM)) o_retry_cnt <= '0;
            else if (retry_ok)                       o_retry_cnt <= o_retry_cnt + 2'd1;
        end
    end

endmodule
